// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the data-memory load/store sequencer: access sizes,
// FSM state codes and the request legality check.
package data_mem_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH = 10;
    localparam int MEM_DATA_WIDTH = 32;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;
    localparam logic [1:0] MEM_SIZE_X = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_READ  = 2'b01;
    localparam logic [1:0] ST_WRITE = 2'b10;
    localparam logic [1:0] ST_RESP  = 2'b11;

    // A request is rejected without touching memory when its size is illegal,
    // it is misaligned for its size, or it addresses beyond the memory.
    function automatic logic req_is_bad(input logic [1:0] size,
                                        input logic [1:0] addr_lo,
                                        input logic       addr_hi_set);
        logic bad;
        bad = addr_hi_set;
        if (size == MEM_SIZE_X) bad = 1'b1;
        if (size == MEM_SIZE_H && addr_lo[0]) bad = 1'b1;
        if (size == MEM_SIZE_W && addr_lo != 2'b00) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-side request/response channels of the data-memory sequencer.
// Both channels: a transfer happens on a rising edge where valid && ready;
// the producer holds valid and its payload stable until that edge.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl_lsu_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a memory
// word, and merges sub-word store data into the old word.
module data_mem_ctrl_lsu_lane_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        case (lane)
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];

        ld_data = 32'h0;
        case (size)
            MEM_SIZE_B: ld_data = is_unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            MEM_SIZE_H: ld_data = is_unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            MEM_SIZE_W: ld_data = word;
            default:    ld_data = 32'h0;
        endcase

        st_data = word;
        case (size)
            MEM_SIZE_B: begin
                case (lane)
                    2'd0: st_data[7:0]   = wdata[7:0];
                    2'd1: st_data[15:8]  = wdata[7:0];
                    2'd2: st_data[23:16] = wdata[7:0];
                    default: st_data[31:24] = wdata[7:0];
                endcase
            end
            MEM_SIZE_H: begin
                if (lane[1]) st_data[31:16] = wdata[15:0];
                else         st_data[15:0]  = wdata[15:0];
            end
            MEM_SIZE_W: st_data = wdata;
            default:    st_data = word;
        endcase
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store sequencer between the core and a word-wide single-port data
// memory; sub-word stores are done as read-modify-write.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = MEM_ADDR_WIDTH,
    parameter int DATA_W = MEM_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_ctrl_if.slave    bus,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state_dbg
);
    logic [1:0]  state;
    logic        lat_we;
    logic        lat_unsigned;
    logic [1:0]  lat_size;
    logic [1:0]  lat_lane;
    logic [31:0] lat_wdata;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    logic        accept_bad;

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    // Decoded from state so an asynchronous reset kills a write immediately.
    assign mem_we        = (state == ST_WRITE);
    assign state_dbg     = state;

    assign accept_bad = req_is_bad(bus.req_size, bus.req_addr[1:0],
                                   |bus.req_addr[ADDR_W-1:MEM_AW+2]);

    data_mem_ctrl_lsu_lane_align u_align (
        .word        (mem_rdata),
        .wdata       (lat_wdata),
        .lane        (lat_lane),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .ld_data     (ld_data),
        .st_data     (st_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            lat_we        <= 1'b0;
            lat_unsigned  <= 1'b0;
            lat_size      <= MEM_SIZE_B;
            lat_lane      <= 2'b00;
            lat_wdata     <= 32'h0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_we       <= bus.req_we;
                        lat_unsigned <= bus.req_unsigned;
                        lat_size     <= bus.req_size;
                        lat_lane     <= bus.req_addr[1:0];
                        lat_wdata    <= bus.req_wdata;
                        mem_addr     <= bus.req_addr[MEM_AW+1:2];
                        if (accept_bad) begin
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= 32'h0;
                            state         <= ST_RESP;
                        end else if (bus.req_we && bus.req_size == MEM_SIZE_W) begin
                            mem_wdata <= bus.req_wdata;
                            state     <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (lat_we) begin
                        mem_wdata <= st_data;
                        state     <= ST_WRITE;
                    end else begin
                        bus.rsp_rdata <= ld_data;
                        state         <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    bus.rsp_rdata <= 32'h0;
                    state         <= ST_RESP;
                end
                default: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_err <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios plus randomized traffic checked
// against a byte-level reference memory model.
module tb_data_mem_ctrl;
    localparam int MEM_AW = 10;
    localparam int WORDS  = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [1:0]        state_dbg;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    logic [31:0] mem     [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    logic [31:0] exp_q[$];

    data_mem_ctrl_if #(.ADDR_W(32)) bus ();

    data_mem_ctrl #(.ADDR_W(32), .MEM_AW(MEM_AW), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Single-port memory: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    // Reference model: computes response, error and latency from the access rules.
    function automatic void model_op(input logic we, input logic [1:0] size, input logic uns,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic [31:0] rd, output logic err, output int lat);
        int unsigned w, off;
        logic [31:0] old, v, mask;
        w   = addr / 4;
        off = addr % 4;
        err = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) ||
              (size == 2'd2 && off != 0) || (addr >= 4 * WORDS);
        rd  = 32'h0;
        lat = 1;
        if (err) return;
        old = ref_mem[w];
        if (!we) begin
            lat = 2;
            if (size == 2'd0) begin
                v  = (old >> (8 * off)) & 32'hFF;
                rd = (!uns && v >= 128) ? v + 32'hFFFFFF00 : v;
            end else if (size == 2'd1) begin
                v  = (old >> (8 * off)) & 32'hFFFF;
                rd = (!uns && v >= 32768) ? v + 32'hFFFF0000 : v;
            end else begin
                rd = old;
            end
        end else begin
            lat  = (size == 2'd2) ? 2 : 3;
            mask = (size == 2'd0) ? (32'hFF << (8 * off)) :
                   (size == 2'd1) ? (32'hFFFF << (8 * off)) : 32'hFFFFFFFF;
            ref_mem[w] = (old & ~mask) | ((wdata << (8 * off)) & mask);
        end
    endfunction

    // Issues one request, scrambles the request bus after accept, waits for the
    // response and completes the handshake. lat counts edges from accept (=1).
    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output int we_at);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.rsp_ready    = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = $urandom_range(0, 1);
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        lat   = 1;
        we_at = mem_we ? 1 : 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_we && we_at == 0) we_at = lat;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        if (!bus.rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=0 after %0d cycles, required 1", lat);
            return;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (state_dbg !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, mrd; logic err, merr; int lat, mlat, we_at;
        model_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, mrd, merr, mlat);
        drive_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, err, lat, we_at);
        checks++; if (we_at !== 1) begin errors++; $display("FAIL sw_we_cycle: got %0d want 1", we_at); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_word4: got %h want deadbeef", mem[4]); end
        checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL sw_rsp: got %h/%b want 0/0", rd, err); end
        model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, mrd, merr, mlat);
        drive_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, err, lat, we_at);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
    endtask

    task automatic test_sub_word();
        logic [31:0] rd, mrd; logic err, merr; int lat, mlat, we_at;
        logic [31:0] a_tab [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
        logic [1:0]  s_tab [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        u_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] e_tab [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DE55};
        model_op(1'b1, 2'd0, 1'b0, 32'h12, 32'h55, mrd, merr, mlat);
        drive_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h55, rd, err, lat, we_at);
        checks++; if (mem[4] !== 32'hDE55BEEF) begin errors++; $display("FAIL sb_word4: got %h want de55beef", mem[4]); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d want 3", lat); end
        checks++; if (we_at !== 2) begin errors++; $display("FAIL sb_we_cycle: got %0d want 2", we_at); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sb_err: got %b want 0", err); end
        for (int i = 0; i < 4; i++) begin
            model_op(1'b0, s_tab[i], u_tab[i], a_tab[i], 32'h0, mrd, merr, mlat);
            drive_req(1'b0, s_tab[i], u_tab[i], a_tab[i], 32'h0, rd, err, lat, we_at);
            checks++; if (rd !== e_tab[i]) begin errors++; $display("FAIL subload_%0d: got %h want %h", i, rd, e_tab[i]); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, mrd; logic err, merr; int lat, mlat, we_at, we_before;
        logic [31:0] snap4;
        logic        w_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  s_tab [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        logic [31:0] a_tab [4] = '{32'h11, 32'h13, 32'h10, 32'h1000};
        snap4 = mem[4];
        we_before = we_cnt;
        for (int i = 0; i < 4; i++) begin
            model_op(w_tab[i], s_tab[i], 1'b0, a_tab[i], 32'hA5A5A5A5, mrd, merr, mlat);
            drive_req(w_tab[i], s_tab[i], 1'b0, a_tab[i], 32'hA5A5A5A5, rd, err, lat, we_at);
            checks++; if (err !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
                errors++; $display("FAIL err_case_%0d: got err=%b rdata=%h lat=%0d want 1/0/1", i, err, rd, lat); end
        end
        checks++; if (we_cnt !== we_before) begin errors++; $display("FAIL err_mem_we: got %0d writes want 0", we_cnt - we_before); end
        checks++; if (mem[4] !== snap4) begin errors++; $display("FAIL err_word4: got %h want %h", mem[4], snap4); end
    endtask

    task automatic test_stall();
        logic [31:0] held; int wait_cyc;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_addr = 32'h20;
        wait_cyc = 0;
        while (!bus.rsp_valid && wait_cyc < 10) begin @(posedge clk); #1; wait_cyc++; end
        held = bus.rsp_rdata;
        checks++; if (held !== 32'hDE55BEEF) begin errors++; $display("FAIL stall_rdata: got %h want de55beef", held); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.req_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold_%0d: got valid=%b rdata=%h ready=%b want 1/%h/0",
                                   i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, held); end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checks++; if (state_dbg !== 2'b00 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: got state=%0d valid=%b want 0/0", state_dbg, bus.rsp_valid); end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] snap8;
        snap8 = mem[8];
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd1;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h22; bus.req_wdata = 32'h1234; bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_write_reached: mem_we=%b want 1", mem_we); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || state_dbg !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_abort: got we=%b state=%0d valid=%b ready=%b want 0/0/0/1",
                               mem_we, state_dbg, bus.rsp_valid, bus.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_rsp_%0d: got %b want 0", i, bus.rsp_valid); end
        end
        checks++; if (mem[8] !== snap8) begin errors++; $display("FAIL rst_word8: got %h want %h", mem[8], snap8); end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, addr, wdata, exp_rd; logic err, merr, we, uns; logic [1:0] size;
        int lat, mlat, we_at, w;
        for (int n = 0; n < 150; n++) begin
            we    = $urandom_range(0, 1);
            size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns   = $urandom_range(0, 1);
            addr  = ($urandom_range(0, 15) == 0) ? 32'h1000 + $urandom_range(0, 255) : $urandom_range(0, 63);
            wdata = $urandom;
            model_op(we, size, uns, addr, wdata, mrd, merr, mlat);
            exp_q.push_back(mrd);
            drive_req(we, size, uns, addr, wdata, rd, err, lat, we_at);
            exp_rd = exp_q.pop_front();
            checks++; if (rd !== exp_rd || err !== merr || lat !== mlat) begin
                errors++; $display("FAIL rand_%0d: addr=%h we=%b size=%0d got %h/%b/%0d want %h/%b/%0d",
                                   n, addr, we, size, rd, err, lat, exp_rd, merr, mlat); end
            if (we && !merr) begin
                w = int'(addr / 4);
                checks++; if (mem[w] !== ref_mem[w]) begin
                    errors++; $display("FAIL rand_mem_%0d: word %0d got %h want %h", n, w, mem[w], ref_mem[w]); end
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_store_load();
        test_sub_word();
        test_errors();
        test_stall();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
